// File: rtl/multi_issue_scoreboard.sv
// Multi-issue in-order scoreboard: circular buffer with writeback, prefix commit and rd lookup.
// Optional define SCOREBOARD_FORWARD_EN enables forwarding of completed results to lookups.
module multi_issue_scoreboard #(
    parameter int unsigned NR_ENTRIES      = 8,
    parameter int unsigned ISSUE_WIDTH     = 2,
    parameter int unsigned NR_WB_PORTS     = 4,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_RS           = 2,
    parameter int unsigned XLEN            = 64,
    localparam int unsigned IDW            = $clog2(NR_ENTRIES)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic [ISSUE_WIDTH-1:0]               issue_valid_i,
    input  logic [ISSUE_WIDTH-1:0][4:0]          issue_rd_i,
    output logic [ISSUE_WIDTH-1:0]               issue_ready_o,
    output logic [ISSUE_WIDTH-1:0][IDW-1:0]      issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]               wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][IDW-1:0]      wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]     wb_data_i,
    output logic [NR_COMMIT_PORTS-1:0]           commit_valid_o,
    output logic [NR_COMMIT_PORTS-1:0][4:0]      commit_rd_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] commit_data_o,
    input  logic [NR_COMMIT_PORTS-1:0]           commit_ack_i,
    input  logic [NR_RS-1:0][4:0]                rs_addr_i,
    output logic [NR_RS-1:0]                     rs_busy_o,
    output logic [NR_RS-1:0]                     rs_fwd_valid_o,
    output logic [NR_RS-1:0][XLEN-1:0]           rs_fwd_data_o,
    output logic [IDW:0]                         count_o,
    output logic                                 full_o,
    output logic                                 empty_o
);

    localparam logic [IDW:0] DEPTH = (IDW+1)'(NR_ENTRIES);

    logic [IDW:0]                         head_q, head_d, tail_q, tail_d;
    logic [NR_ENTRIES-1:0]                busy_q, busy_d, done_q, done_d;
    logic [NR_ENTRIES-1:0][4:0]           rd_q, rd_d;
    logic [NR_ENTRIES-1:0][XLEN-1:0]      data_q, data_d;

    logic [IDW:0]                         count;
    logic [IDW:0]                         free_cnt;
    logic [IDW:0]                         acc_cnt;
    logic [IDW:0]                         ret_cnt;
    logic [IDW-1:0]                       head_idx;
    logic [IDW-1:0]                       tail_idx;
    logic [IDW-1:0]                       issue_idx;
    logic                                 issue_run;
    logic [ISSUE_WIDTH-1:0]               lane_acc;
    logic                                 commit_run;
    logic                                 retire_run;
    logic [NR_COMMIT_PORTS-1:0]           retire;
    logic [NR_COMMIT_PORTS-1:0][IDW-1:0]  commit_idx;
    logic [NR_RS-1:0]                     lk_found;
    logic [IDW-1:0]                       lk_scan;
`ifdef SCOREBOARD_FORWARD_EN
    logic [NR_RS-1:0][IDW-1:0]            lk_idx;
`endif

    assign count    = tail_q - head_q;
    assign head_idx = head_q[IDW-1:0];
    assign tail_idx = tail_q[IDW-1:0];
    assign free_cnt = DEPTH - count;
    assign count_o  = count;
    assign full_o   = (count == DEPTH);
    assign empty_o  = (count == '0);

    // Issue: lanes accepted as a contiguous prefix, limited by free space at cycle start.
    always_comb begin
        issue_ready_o    = '0;
        issue_trans_id_o = '0;
        lane_acc         = '0;
        acc_cnt          = '0;
        issue_run        = 1'b1;
        for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            issue_ready_o[k]    = free_cnt > (IDW+1)'(k);
            issue_trans_id_o[k] = tail_idx + IDW'(k);
            issue_run           = issue_run & issue_valid_i[k] & issue_ready_o[k];
            lane_acc[k]         = issue_run & ~flush_i;
            if (lane_acc[k]) begin
                acc_cnt = acc_cnt + (IDW+1)'(1);
            end
        end
    end

    // Commit: oldest entries in order; retirement needs a matching ack prefix.
    always_comb begin
        commit_valid_o = '0;
        commit_rd_o    = '0;
        commit_data_o  = '0;
        commit_idx     = '0;
        retire         = '0;
        ret_cnt        = '0;
        commit_run     = 1'b1;
        retire_run     = 1'b1;
        for (int j = 0; j < int'(NR_COMMIT_PORTS); j++) begin
            commit_idx[j]     = head_idx + IDW'(j);
            commit_run        = commit_run & busy_q[commit_idx[j]] & done_q[commit_idx[j]];
            commit_valid_o[j] = commit_run;
            if (commit_run) begin
                commit_rd_o[j]   = rd_q[commit_idx[j]];
                commit_data_o[j] = data_q[commit_idx[j]];
            end
            retire_run = retire_run & commit_run & commit_ack_i[j];
            retire[j]  = retire_run & ~flush_i;
            if (retire[j]) begin
                ret_cnt = ret_cnt + (IDW+1)'(1);
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q;
        rd_d      = rd_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        issue_idx = '0;
        if (flush_i) begin
            busy_d = '0;
            done_d = '0;
            head_d = '0;
            tail_d = '0;
        end else begin
            // Descending port scan so the lowest-numbered port has the final say.
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
                    if (wb_valid_i[p] && (wb_trans_id_i[p] == IDW'(i)) && busy_q[i]) begin
                        done_d[i] = 1'b1;
                        data_d[i] = wb_data_i[p];
                    end
                end
            end
            for (int j = 0; j < int'(NR_COMMIT_PORTS); j++) begin
                if (retire[j]) begin
                    busy_d[commit_idx[j]] = 1'b0;
                    done_d[commit_idx[j]] = 1'b0;
                end
            end
            for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
                if (lane_acc[k]) begin
                    issue_idx         = tail_idx + IDW'(k);
                    busy_d[issue_idx] = 1'b1;
                    done_d[issue_idx] = 1'b0;
                    rd_d[issue_idx]   = issue_rd_i[k];
                end
            end
            head_d = head_q + ret_cnt;
            tail_d = tail_q + acc_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    // Lookup scans oldest to youngest from head so the last hit is the youngest writer.
    always_comb begin
        lk_found       = '0;
        lk_scan        = '0;
        rs_busy_o      = '0;
        rs_fwd_valid_o = '0;
        rs_fwd_data_o  = '0;
`ifdef SCOREBOARD_FORWARD_EN
        lk_idx         = '0;
`endif
        for (int r = 0; r < int'(NR_RS); r++) begin
            for (int o = 0; o < int'(NR_ENTRIES); o++) begin
                lk_scan = head_idx + IDW'(o);
                if (busy_q[lk_scan] && (rd_q[lk_scan] == rs_addr_i[r]) &&
                    (rs_addr_i[r] != 5'd0)) begin
                    lk_found[r] = 1'b1;
`ifdef SCOREBOARD_FORWARD_EN
                    lk_idx[r]   = lk_scan;
`endif
                end
            end
`ifdef SCOREBOARD_FORWARD_EN
            rs_busy_o[r]      = lk_found[r] & ~done_q[lk_idx[r]];
            rs_fwd_valid_o[r] = lk_found[r] & done_q[lk_idx[r]];
            if (rs_fwd_valid_o[r]) begin
                rs_fwd_data_o[r] = data_q[lk_idx[r]];
            end
`else
            rs_busy_o[r]      = lk_found[r];
`endif
        end
    end

endmodule

// File: tb/tb_multi_issue_scoreboard.sv
// Directed bench for multi_issue_scoreboard; commits are checked by a queue-based monitor.
module tb_multi_issue_scoreboard;

    localparam int NE = 8;
    localparam int IW = 2;
    localparam int NW = 2;
    localparam int NC = 2;
    localparam int NR = 2;
    localparam int XL = 64;
    localparam int IDW = 3;

    typedef struct packed {
        logic [4:0]    rd;
        logic [XL-1:0] data;
    } commit_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [IW-1:0]           issue_valid;
    logic [IW-1:0][4:0]      issue_rd;
    logic [IW-1:0]           issue_ready;
    logic [IW-1:0][IDW-1:0]  issue_trans_id;
    logic [NW-1:0]           wb_valid;
    logic [NW-1:0][IDW-1:0]  wb_trans_id;
    logic [NW-1:0][XL-1:0]   wb_data;
    logic [NC-1:0]           commit_valid;
    logic [NC-1:0][4:0]      commit_rd;
    logic [NC-1:0][XL-1:0]   commit_data;
    logic [NC-1:0]           commit_ack;
    logic [NR-1:0][4:0]      rs_addr;
    logic [NR-1:0]           rs_busy;
    logic [NR-1:0]           rs_fwd_valid;
    logic [NR-1:0][XL-1:0]   rs_fwd_data;
    logic [IDW:0]            count;
    logic                    full;
    logic                    empty;

    int      n_tests = 0;
    int      n_fail  = 0;
    commit_t exp_q[$];

    multi_issue_scoreboard #(
        .NR_ENTRIES      (NE),
        .ISSUE_WIDTH     (IW),
        .NR_WB_PORTS     (NW),
        .NR_COMMIT_PORTS (NC),
        .NR_RS           (NR),
        .XLEN            (XL)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .issue_valid_i    (issue_valid),
        .issue_rd_i       (issue_rd),
        .issue_ready_o    (issue_ready),
        .issue_trans_id_o (issue_trans_id),
        .wb_valid_i       (wb_valid),
        .wb_trans_id_i    (wb_trans_id),
        .wb_data_i        (wb_data),
        .commit_valid_o   (commit_valid),
        .commit_rd_o      (commit_rd),
        .commit_data_o    (commit_data),
        .commit_ack_i     (commit_ack),
        .rs_addr_i        (rs_addr),
        .rs_busy_o        (rs_busy),
        .rs_fwd_valid_o   (rs_fwd_valid),
        .rs_fwd_data_o    (rs_fwd_data),
        .count_o          (count),
        .full_o           (full),
        .empty_o          (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        issue_valid = '0;
        wb_valid    = '0;
        commit_ack  = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic issue2(input logic [4:0] rd0, input logic [4:0] rd1);
        issue_valid = 2'b11;
        issue_rd[0] = rd0;
        issue_rd[1] = rd1;
        tick();
        idle();
    endtask

    // Monitor: every handshaken commit port must match the next expected retirement.
    always @(negedge clk) begin
        if (!rst) begin
            for (int j = 0; j < NC; j++) begin
                if (commit_valid[j] && commit_ack[j]) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL commit_unexpected[%0d]: got rd=%0d data=0x%0h expected none",
                                 j, commit_rd[j], commit_data[j]);
                    end else begin
                        commit_t e;
                        e = exp_q.pop_front();
                        if (commit_rd[j] !== e.rd || commit_data[j] !== e.data) begin
                            n_fail++;
                            $display("FAIL commit[%0d]: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                                     j, commit_rd[j], commit_data[j], e.rd, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        issue_rd    = '0;
        wb_trans_id = '0;
        wb_data     = '0;
        rs_addr     = '0;
        idle();
        @(posedge clk);
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 64'(count), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full", 64'(full), 0);
        chk("rst_ready", 64'(issue_ready), 2'b11);
        chk("rst_tid", 64'(issue_trans_id), {3'd1, 3'd0});
        chk("rst_cvalid", 64'(commit_valid), 0);
        chk("rst_cdata", 64'(commit_data[0] | commit_data[1]), 0);
        chk("rst_rsbusy", 64'(rs_busy), 0);
        chk("rst_fwdv", 64'(rs_fwd_valid), 0);
        chk("rst_fwdd", 64'(rs_fwd_data[0] | rs_fwd_data[1]), 0);

        // Fill: two per cycle, ids 0..7, rd = id+1
        for (int c = 0; c < 4; c++) begin
            chk("fill_tid", 64'(issue_trans_id), {3'(2*c+1), 3'(2*c)});
            issue2(5'(2*c+1), 5'(2*c+2));
        end
        chk("fill_count", 64'(count), 8);
        chk("fill_full", 64'(full), 1);
        chk("fill_ready", 64'(issue_ready), 2'b00);

        // Out-of-order writeback; port 0 beats port 1 on id 0
        wb_valid = 2'b01; wb_trans_id[0] = 3'd1; wb_data[0] = 64'hA;
        tick(); idle();
        chk("wb1_cvalid", 64'(commit_valid), 2'b00);
        wb_valid = 2'b11;
        wb_trans_id[0] = 3'd0; wb_data[0] = 64'hB;
        wb_trans_id[1] = 3'd0; wb_data[1] = 64'hBAD;
        tick(); idle();
        chk("wb0_cvalid", 64'(commit_valid), 2'b11);
        exp_q.push_back('{rd: 5'd1, data: 64'hB});
        exp_q.push_back('{rd: 5'd2, data: 64'hA});
        commit_ack = 2'b11;
        tick(); idle();
        chk("ack_count", 64'(count), 6);
        chk("ack_cvalid", 64'(commit_valid), 2'b00);
        commit_ack = 2'b11;
        tick(); idle();
        chk("stray_ack_count", 64'(count), 6);
        chk("wrap_tid", 64'(issue_trans_id), {3'd1, 3'd0});
        issue2(5'd9, 5'd10);
        chk("refill_count", 64'(count), 8);
        chk("refill_full", 64'(full), 1);

        // Writeback to an idle entry is dropped
        do_flush();
        wb_valid = 2'b01; wb_trans_id[0] = 3'd0; wb_data[0] = 64'hDEAD;
        tick(); idle();
        issue_valid = 2'b01; issue_rd[0] = 5'd7;
        tick(); idle();
        chk("idle_wb_count", 64'(count), 1);
        chk("idle_wb_cvalid", 64'(commit_valid), 2'b00);

        // Simultaneous issue and commit at count 6
        do_flush();
        for (int c = 0; c < 3; c++) issue2(5'd3, 5'd3);
        chk("six_count", 64'(count), 6);
        wb_valid = 2'b11;
        wb_trans_id[0] = 3'd0; wb_data[0] = 64'h100;
        wb_trans_id[1] = 3'd1; wb_data[1] = 64'h101;
        tick(); idle();
        chk("six_cvalid", 64'(commit_valid), 2'b11);
        exp_q.push_back('{rd: 5'd3, data: 64'h100});
        exp_q.push_back('{rd: 5'd3, data: 64'h101});
        issue_valid = 2'b11; issue_rd[0] = 5'd4; issue_rd[1] = 5'd4;
        commit_ack  = 2'b11;
        tick(); idle();
        chk("swap_count", 64'(count), 6);
        chk("swap_full", 64'(full), 0);
        chk("swap_tid", 64'(issue_trans_id), {3'd1, 3'd0});

        // Lookup / forwarding
        do_flush();
        issue2(5'd5, 5'd5);
        rs_addr[0] = 5'd5; rs_addr[1] = 5'd0;
        #1;
        chk("lk_pending_busy", 64'(rs_busy), 2'b01);
        chk("lk_pending_fwd", 64'(rs_fwd_valid), 2'b00);
        wb_valid = 2'b01; wb_trans_id[0] = 3'd1; wb_data[0] = 64'h55;
        #1;
        chk("lk_samecycle_fwd", 64'(rs_fwd_valid), 2'b00);
        chk("lk_samecycle_busy", 64'(rs_busy), 2'b01);
        tick(); idle();
`ifdef SCOREBOARD_FORWARD_EN
        chk("lk_done_busy", 64'(rs_busy), 2'b00);
        chk("lk_done_fwd", 64'(rs_fwd_valid), 2'b01);
        chk("lk_done_data", rs_fwd_data[0], 64'h55);
`else
        chk("lk_done_busy", 64'(rs_busy), 2'b01);
        chk("lk_done_fwd", 64'(rs_fwd_valid), 2'b00);
        chk("lk_done_data", rs_fwd_data[0], 64'h0);
`endif
        chk("lk_x0_data", rs_fwd_data[1], 64'h0);
        issue_valid = 2'b01; issue_rd[0] = 5'd5;
        tick(); idle();
        chk("lk_young_busy", 64'(rs_busy), 2'b01);
        chk("lk_young_fwd", 64'(rs_fwd_valid), 2'b00);

        // Flush overrides issue and writeback
        issue_valid = 2'b11; issue_rd[0] = 5'd6; issue_rd[1] = 5'd6;
        wb_valid = 2'b11; wb_trans_id[0] = 3'd0; wb_trans_id[1] = 3'd2;
        flush = 1'b1;
        tick(); idle();
        chk("flush_count", 64'(count), 0);
        chk("flush_empty", 64'(empty), 1);
        chk("flush_cvalid", 64'(commit_valid), 2'b00);
        chk("flush_tid", 64'(issue_trans_id), {3'd1, 3'd0});
        chk("flush_rsbusy", 64'(rs_busy), 2'b00);

        // Lane above a gap is ignored
        issue_valid = 2'b10; issue_rd[1] = 5'd8;
        tick(); idle();
        chk("gap_count", 64'(count), 0);

        // Reset mid-operation
        issue2(5'd1, 5'd2);
        chk("pre_rst_count", 64'(count), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_empty", 64'(empty), 1);

        tick();
        chk("commit_queue_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
